// File: rtl/cpu_pkg.sv
// Shared pipeline widths and constants for the CPU datapath.
// MEM/WB field widths here are also used by the MEM/WB pipeline register.
package cpu_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;
    localparam int unsigned CNTW = 32;

    localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_2r1w.sv
// GPR storage: two combinational read ports, one write port, synchronous clear.
// Entry 0 is never written and always reads as zero.
module regfile_2r1w
    import cpu_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_a_o,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] mem_q [NREG];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != REG_ZERO)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = (raddr_a_i == REG_ZERO) ? '0 : mem_q[raddr_a_i];
        rdata_b_o = (raddr_b_i == REG_ZERO) ? '0 : mem_q[raddr_b_i];
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: MemtoReg select, GPR commit, read ports with write-through
// bypass, a one-entry retire record for EX forwarding and a commit counter.
module wb_regfile
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   Do_5,
    input  logic [DW-1:0]   ALUout_5,
    input  logic [AW-1:0]   rw_5,
    input  logic            MemtoReg_5,
    input  logic            RegWr_5,
    input  logic [AW-1:0]   ra,
    input  logic [AW-1:0]   rb,
    output logic [DW-1:0]   busA,
    output logic [DW-1:0]   busB,
    output logic [DW-1:0]   busW,
    output logic            ret_vld,
    output logic [AW-1:0]   ret_rw,
    output logic [DW-1:0]   ret_data,
    output logic [CNTW-1:0] wb_cnt
);

    logic          commit;
    logic [DW-1:0] gpr_a;
    logic [DW-1:0] gpr_b;

    logic            ret_vld_q;
    logic [AW-1:0]   ret_rw_q;
    logic [DW-1:0]   ret_data_q;
    logic [CNTW-1:0] wb_cnt_q;
    logic [CNTW-1:0] wb_cnt_d;

    assign busW   = MemtoReg_5 ? Do_5 : ALUout_5;
    assign commit = RegWr_5 && (rw_5 != REG_ZERO) && rst_n;

    regfile_2r1w u_regfile (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .we_i      (commit),
        .waddr_i   (rw_5),
        .wdata_i   (busW),
        .raddr_a_i (ra),
        .raddr_b_i (rb),
        .rdata_a_o (gpr_a),
        .rdata_b_o (gpr_b)
    );

    // Bypass ignores rst_n so ID sees busW even while the write is being dropped.
    always_comb begin
        busA = gpr_a;
        busB = gpr_b;
        if (ra == REG_ZERO) begin
            busA = '0;
        end else if (RegWr_5 && (rw_5 == ra)) begin
            busA = busW;
        end
        if (rb == REG_ZERO) begin
            busB = '0;
        end else if (RegWr_5 && (rw_5 == rb)) begin
            busB = busW;
        end
    end

    always_comb begin
        wb_cnt_d = wb_cnt_q;
        if (commit) begin
            wb_cnt_d = wb_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ret_vld_q  <= 1'b0;
            ret_rw_q   <= '0;
            ret_data_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            ret_vld_q  <= commit;
            ret_rw_q   <= rw_5;
            ret_data_q <= busW;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign ret_vld  = ret_vld_q;
    assign ret_rw   = ret_rw_q;
    assign ret_data = ret_data_q;
    assign wb_cnt   = wb_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected output values,
// a negedge monitor pops and compares them against the DUT.
module tb_wb_regfile;
    import cpu_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   Do_5;
    logic [DW-1:0]   ALUout_5;
    logic [AW-1:0]   rw_5;
    logic            MemtoReg_5;
    logic            RegWr_5;
    logic [AW-1:0]   ra;
    logic [AW-1:0]   rb;
    logic [DW-1:0]   busA;
    logic [DW-1:0]   busB;
    logic [DW-1:0]   busW;
    logic            ret_vld;
    logic [AW-1:0]   ret_rw;
    logic [DW-1:0]   ret_data;
    logic [CNTW-1:0] wb_cnt;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Do_5       (Do_5),
        .ALUout_5   (ALUout_5),
        .rw_5       (rw_5),
        .MemtoReg_5 (MemtoReg_5),
        .RegWr_5    (RegWr_5),
        .ra         (ra),
        .rb         (rb),
        .busA       (busA),
        .busB       (busB),
        .busW       (busW),
        .ret_vld    (ret_vld),
        .ret_rw     (ret_rw),
        .ret_data   (ret_data),
        .wb_cnt     (wb_cnt)
    );

    typedef enum logic [2:0] {
        SigBusA, SigBusB, SigBusW, SigRetVld, SigRetRw, SigRetData, SigWbCnt
    } sig_e;

    typedef struct {
        sig_e        sig;
        logic [31:0] exp;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] actual_of(sig_e s);
        case (s)
            SigBusA:    return busA;
            SigBusB:    return busB;
            SigBusW:    return busW;
            SigRetVld:  return {31'd0, ret_vld};
            SigRetRw:   return {27'd0, ret_rw};
            SigRetData: return ret_data;
            default:    return wb_cnt;
        endcase
    endfunction

    // Monitor: everything queued since the last posedge is due at this negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = exp_q.pop_front();
            act = actual_of(e.sig);
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL t%0d %s: got %h expected %h", e.tag, e.sig.name(), act, e.exp);
            end
        end
    end

    // Watchdog: the run must finish well before this bound.
    initial begin
        #100000;
        failures++;
        $display("FAIL timeout: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic check_now(input sig_e s, input logic [31:0] v, input int tag);
        logic [31:0] act;
        act = actual_of(s);
        checks++;
        if (act !== v) begin
            failures++;
            $display("FAIL t%0d %s (direct): got %h expected %h", tag, s.name(), act, v);
        end
    endtask

    task automatic push(input sig_e s, input logic [31:0] v, input int tag);
        exp_t e;
        e.sig = s;
        e.exp = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [AW-1:0] rw,
                         input logic [DW-1:0] alu, input logic [DW-1:0] dout);
        RegWr_5    = we;
        MemtoReg_5 = m2r;
        rw_5       = rw;
        ALUout_5   = alu;
        Do_5       = dout;
    endtask

    initial begin
        rst_n = 1'b0;
        ra    = '0;
        rb    = '0;
        drive(1'b0, 1'b0, '0, '0, '0);
        step();
        step();
        check_now(SigWbCnt, 32'd0, 0);
        check_now(SigRetVld, 32'd0, 0);
        check_now(SigRetRw, 32'd0, 0);
        check_now(SigRetData, 32'd0, 0);
        check_now(SigBusA, 32'd0, 0);
        rst_n = 1'b1;

        // 1: preload r5, then reset clears it
        drive(1'b1, 1'b0, 5'd5, 32'hAAAA_5555, 32'h0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        ra = 5'd5;
        push(SigBusA, 32'hAAAA_5555, 1);
        push(SigWbCnt, 32'd1, 1);
        step();
        rst_n = 1'b0;
        step();
        push(SigBusA, 32'h0, 1);
        push(SigWbCnt, 32'd0, 1);
        push(SigRetVld, 32'd0, 1);
        step();
        rst_n = 1'b1;

        // 2: ALU write to r7
        drive(1'b1, 1'b0, 5'd7, 32'h1234_5678, 32'hCAFE_0000);
        ra = 5'd0;
        rb = 5'd0;
        push(SigBusW, 32'h1234_5678, 2);
        push(SigBusA, 32'h0, 2);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        ra = 5'd7;
        push(SigBusA, 32'h1234_5678, 2);
        push(SigRetVld, 32'd1, 2);
        push(SigRetRw, 32'd7, 2);
        push(SigRetData, 32'h1234_5678, 2);
        push(SigWbCnt, 32'd1, 2);
        step();

        // 3: load write to r9 with same-cycle bypass on both ports
        drive(1'b1, 1'b1, 5'd9, 32'h0BAD_0BAD, 32'hDEAD_BEEF);
        ra = 5'd9;
        rb = 5'd9;
        push(SigBusW, 32'hDEAD_BEEF, 3);
        push(SigBusA, 32'hDEAD_BEEF, 3);
        push(SigBusB, 32'hDEAD_BEEF, 3);
        step();
        drive(1'b0, 1'b0, 5'd9, 32'h0, 32'h0);
        rb = 5'd7;
        push(SigBusA, 32'hDEAD_BEEF, 3);
        push(SigBusB, 32'h1234_5678, 3);
        push(SigWbCnt, 32'd2, 3);
        step();

        // 4: x0 guard
        drive(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0);
        ra = 5'd0;
        rb = 5'd0;
        push(SigBusA, 32'h0, 4);
        push(SigBusW, 32'hFFFF_FFFF, 4);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        push(SigBusA, 32'h0, 4);
        push(SigWbCnt, 32'd2, 4);
        push(SigRetVld, 32'd0, 4);
        step();

        // 5: reset beats a simultaneous write; bypass still visible during reset
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 5'd3, 32'h0000_0033, 32'h0);
        ra = 5'd3;
        push(SigBusA, 32'h0000_0033, 5);
        step();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        rb = 5'd9;
        push(SigBusA, 32'h0, 5);
        push(SigBusB, 32'h0, 5);
        push(SigWbCnt, 32'd0, 5);
        push(SigRetVld, 32'd0, 5);
        step();

        // 6: back-to-back writes to r4, last one wins
        drive(1'b1, 1'b0, 5'd4, 32'h0000_0001, 32'h0);
        step();
        drive(1'b1, 1'b0, 5'd4, 32'h0000_0002, 32'h0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        ra = 5'd4;
        push(SigBusA, 32'h0000_0002, 6);
        push(SigRetData, 32'h0000_0002, 6);
        push(SigWbCnt, 32'd2, 6);
        step();

        // 7: counter wraps from all-ones to zero
        force dut.wb_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_cnt_q;
        push(SigWbCnt, 32'hFFFF_FFFF, 7);
        drive(1'b1, 1'b0, 5'd6, 32'h0000_0066, 32'h0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        ra = 5'd6;
        push(SigWbCnt, 32'd0, 7);
        push(SigBusA, 32'h0000_0066, 7);
        push(SigRetVld, 32'd1, 7);
        push(SigRetRw, 32'd6, 7);
        step();

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
